// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline stall/flush sequencer.
package pipeline_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, STEP} ctrl_state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } ctrl_out_t;

  //                                         pc  ifen iff  idf  exen mwf
  localparam ctrl_out_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_out_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_out_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_out_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_out_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam ctrl_out_t CTRL_RST    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the EX load and the ID operands.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic       mem_read_ex,
  input  logic [4:0] rd_ex,
  output logic       load_use
);

  assign load_use = mem_read_ex && (rd_ex != REG_ZERO) &&
                    ((rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards, redirects, memory waits, debug halt.
// Define PIPELINE_PERF_CNT_EN to build the stall_cnt / flush_cnt performance counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic        mem_read_ex,
  input  logic [4:0]  rd_ex,
  input  logic        redirect_ex,
  input  logic        dmem_req_mem,
  input  logic        dmem_ready_mem,
  input  logic        halt_req,
  input  logic        step_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic        mem_err
`ifdef PIPELINE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  ctrl_state_e state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        err_nx;
  logic        lu_block;
  logic        lu_stall;
  logic        load_use;
  logic        mem_wait;
  ctrl_out_t   ctl;

  hazard_detect u_hazard (
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .mem_read_ex (mem_read_ex),
    .rd_ex       (rd_ex),
    .load_use    (load_use)
  );

  assign mem_wait = dmem_req_mem && !dmem_ready_mem;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = mem_err;
    ctl      = CTRL_RUN;
    lu_stall = 1'b0;
    if (state == HALTED) begin
      ctl = CTRL_FREEZE;
      if (!mem_err) begin
        if (step_req)      state_nx = STEP;
        else if (!halt_req) state_nx = RUN;
      end
    end else if (state == MEM_WAIT && !dmem_ready_mem) begin
      ctl = CTRL_FREEZE;
      if (cnt >= TIMEOUT) begin
        err_nx   = 1'b1;
        state_nx = HALTED;
      end else begin
        cnt_nx = cnt + 8'd1;
      end
    end else begin
      // RUN, STEP, and the MEM_WAIT release cycle share the RUN priority chain.
      // A step ignores the (still held) halt request so it actually advances.
      if (mem_wait) begin
        ctl      = CTRL_FREEZE;
        state_nx = MEM_WAIT;
        cnt_nx   = 8'd1;
      end else if (halt_req && state != STEP) begin
        ctl      = CTRL_HOLD;
        state_nx = HALTED;
      end else begin
        if (redirect_ex) begin
          ctl = CTRL_REDIR;
        end else if (load_use && !lu_block) begin
          ctl      = CTRL_LU;
          lu_stall = 1'b1;
        end
        state_nx = (state == STEP) ? HALTED : RUN;
      end
    end
    if (!rst_n) ctl = CTRL_RST;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      cnt      <= '0;
      mem_err  <= 1'b0;
      lu_block <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      mem_err  <= err_nx;
      lu_block <= lu_stall;  // a given hazard stalls only once
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_flush = ctl.mem_wb_flush;
  assign halted       = (state == HALTED);

`ifdef PIPELINE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctl.pc_en && state != HALTED) stall_cnt <= stall_cnt + 32'd1;
      if (ctl.if_id_flush || lu_stall)   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven, scoreboarded bench for pipeline_ctrl (optionally with PIPELINE_PERF_CNT_EN).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        rs1_used_id, rs2_used_id, mem_read_ex, redirect_ex;
  logic        dmem_req_mem, dmem_ready_mem, halt_req, step_req;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic        halted, mem_err;
`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .rs1_used_id    (rs1_used_id),
    .rs2_used_id    (rs2_used_id),
    .mem_read_ex    (mem_read_ex),
    .rd_ex          (rd_ex),
    .redirect_ex    (redirect_ex),
    .dmem_req_mem   (dmem_req_mem),
    .dmem_ready_mem (dmem_ready_mem),
    .halt_req       (halt_req),
    .step_req       (step_req),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_flush   (mem_wb_flush),
    .halted         (halted),
    .mem_err        (mem_err)
`ifdef PIPELINE_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  // expected {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush, halted, mem_err}
  localparam logic [7:0] O_RUN  = 8'b1100_1000;
  localparam logic [7:0] O_LU   = 8'b0001_1000;
  localparam logic [7:0] O_RED  = 8'b1111_1000;
  localparam logic [7:0] O_MW   = 8'b0000_0100;
  localparam logic [7:0] O_HENT = 8'b0000_0000;
  localparam logic [7:0] O_HLT  = 8'b0000_0110;
  localparam logic [7:0] O_HERR = 8'b0000_0111;
  localparam logic [7:0] O_RST  = 8'b0011_0100;
  localparam logic [7:0] O_RSTE = 8'b0011_0111;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, mrd;
    logic [4:0] rd;
    logic       redir, req, rdy, halt, step;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    bit          is_perf;
    logic [7:0]  exp;
    logic [31:0] exp_stall, exp_flush;
  } sb_t;

  sb_t sb[$];
  sb_t cur;
  int  vectors = 0;
  int  miscompares = 0;
  vec_t tbl[$];

  function automatic vec_t mk(string n, logic r, logic [4:0] s1, logic [4:0] s2, logic a1, logic a2,
                              logic m, logic [4:0] d, logic rd_, logic rq, logic ry, logic h, logic s,
                              logic [7:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.rs1 = s1; v.rs2 = s2; v.u1 = a1; v.u2 = a2; v.mrd = m; v.rd = d;
    v.redir = rd_; v.req = rq; v.rdy = ry; v.halt = h; v.step = s; v.exp = e;
    return v;
  endfunction

  // idle vector with only memory/debug controls set
  function automatic vec_t ctl(string n, logic r, logic rq, logic ry, logic h, logic s, logic [7:0] e);
    return mk(n, r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, rq, ry, h, s, e);
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    @(posedge clk); #1;
    rst_n = v.rst; rs1_id = v.rs1; rs2_id = v.rs2; rs1_used_id = v.u1; rs2_used_id = v.u2;
    mem_read_ex = v.mrd; rd_ex = v.rd; redirect_ex = v.redir; dmem_req_mem = v.req;
    dmem_ready_mem = v.rdy; halt_req = v.halt; step_req = v.step;
    e.name = v.name; e.is_perf = 1'b0; e.exp = v.exp; e.exp_stall = '0; e.exp_flush = '0;
    sb.push_back(e);
  endtask

  task automatic reset_only();
    @(posedge clk); #1;
    rst_n = 1'b0; dmem_req_mem = 1'b0; dmem_ready_mem = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    redirect_ex = 1'b0; mem_read_ex = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      vectors++;
      if (cur.is_perf) begin
`ifdef PIPELINE_PERF_CNT_EN
        if (stall_cnt !== cur.exp_stall || flush_cnt !== cur.exp_flush) begin
          miscompares++;
          $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d, expected %0d/%0d",
                   cur.name, stall_cnt, flush_cnt, cur.exp_stall, cur.exp_flush);
        end
`endif
      end else if ({pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush, halted, mem_err}
                   !== cur.exp) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", cur.name,
                 {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_flush, halted, mem_err},
                 cur.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; rs1_id = '0; rs2_id = '0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    mem_read_ex = 1'b0; rd_ex = '0; redirect_ex = 1'b0; dmem_req_mem = 1'b0;
    dmem_ready_mem = 1'b0; halt_req = 1'b0; step_req = 1'b0;

    // RUN-state vectors: one cycle each, in order
    tbl.push_back(ctl("reset_outputs", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST));
    tbl.push_back(ctl("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("lu_rs1", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
    tbl.push_back(mk("lu_rs1_once", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(ctl("idle2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("lu_rd0", 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("lu_rs2", 1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
    tbl.push_back(ctl("idle3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("rs2_unused", 1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("no_load", 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("redir_lu", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RED));
    tbl.push_back(mk("redir_lu2", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RED));
    tbl.push_back(ctl("mem_ready_now", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN));
    // 3-cycle memory wait, then release on ready
    for (int i = 0; i < 3; i++) tbl.push_back(ctl("mw_freeze", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_MW));
    tbl.push_back(ctl("mw_release", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN));
    tbl.push_back(ctl("mw_back_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    // debug halt / single step / resume
    tbl.push_back(ctl("halt_entry", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_HENT));
    tbl.push_back(ctl("halted", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_HLT));
    tbl.push_back(ctl("step_pulse", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_HLT));
    tbl.push_back(ctl("step_cycle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_RUN));
    tbl.push_back(ctl("step_rehalt", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_HLT));
    tbl.push_back(ctl("halt_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_HLT));
    tbl.push_back(ctl("resumed", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
    // reset mid-wait
    tbl.push_back(ctl("rw_enter", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_MW));
    tbl.push_back(ctl("rw_wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_MW));
    tbl.push_back(ctl("rw_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_RST));
    tbl.push_back(ctl("rw_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));

    apply(ctl("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'bxxxx_xxxx)); // state unknown before first edge
    void'(sb.pop_back());
    foreach (tbl[i]) apply(tbl[i]);

    // memory timeout: 1 RUN wait cycle + 16 MEM_WAIT cycles, then sticky error halt
    for (int i = 0; i < 17; i++) apply(ctl("tmo_wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_MW));
    apply(ctl("tmo_halted", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_HERR));
    apply(ctl("tmo_halt_hi", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, O_HERR));
    apply(ctl("tmo_halt_lo", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_HERR));
    apply(ctl("tmo_step", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_HERR));
    apply(ctl("tmo_sticky", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_HERR));
    apply(ctl("tmo_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RSTE));
    apply(ctl("tmo_cleared", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));

`ifdef PIPELINE_PERF_CNT_EN
    begin
      sb_t p;
      reset_only();
      apply(mk("pc_lu", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
      apply(ctl("pc_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
      for (int i = 0; i < 3; i++) apply(ctl("pc_mw", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_MW));
      apply(ctl("pc_rel", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN));
      apply(ctl("pc_idle2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN));
      p.name = "perf_counters"; p.is_perf = 1'b1; p.exp = '0;
      p.exp_stall = 32'd4; p.exp_flush = 32'd1;
      sb.push_back(p);
    end
`endif

    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
